// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency single-port memory between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times; a watchdog bounds m_ack waits.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    WDOG_MAX   = 8'(TIMEOUT);
  localparam logic [31:0]   NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, next_state;
  logic            owner_data;
  logic [SW-1:0]   starve_cnt;
  logic [7:0]      wdog;
  logic            grant_fetch, grant_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (starve_cnt == STARVE_MAX) grant_fetch = 1'b1;
          else                          grant_data  = 1'b1;
        end else if (d_req) begin
          grant_data = 1'b1;
        end else if (i_req) begin
          grant_fetch = 1'b1;
        end
        if (grant_fetch || grant_data) next_state = BUSY;
      end
      BUSY: begin
        if (m_ack || (wdog == WDOG_MAX)) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_req  = (state == BUSY);
    i_done = (state == DONE) && !owner_data;
    d_done = (state == DONE) &&  owner_data;
    stall  = (i_req && !i_done) || (d_req && !d_done);
  end

  // Latched request, watchdog and returned data; m_ack wins over a simultaneous watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_data  <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      starve_cnt  <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner_data <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            wdog       <= '0;
            if (i_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_fetch) begin
            owner_data <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            wdog       <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          if (m_ack) begin
            if (owner_data) d_rdata <= m_we ? 32'h0 : m_rdata;
            else            i_rdata <= m_rdata;
          end else if (wdog == WDOG_MAX) begin
            timeout_err <= 1'b1;
            if (owner_data) d_rdata <= 32'h0;
            else            i_rdata <= NOP_INSN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a responder model drives the memory side and
// scoreboards hold the expected grant order and completion data.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_done, d_done, m_req, m_we, stall, timeout_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

  typedef struct packed {logic is_data; logic [31:0] rdata;} done_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} grant_t;

  done_t  done_q[$];
  grant_t grant_q[$];
  int     compared = 0;
  int     mismatched = 0;
  bit     seen_done;
  logic   prev_m_req;
  bit     ack_enable;
  int     ack_delay;
  bit     force_ack;
  int     busy_cycles;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: acks once m_req has been high for ack_delay cycles, else drives force_ack.
  initial begin
    m_ack = 1'b0;
    m_rdata = '0;
    busy_cycles = 0;
    forever begin
      @(posedge clk);
      #2;
      if (m_req === 1'b1) begin
        if (ack_enable && busy_cycles >= ack_delay) begin
          m_ack = 1'b1;
          m_rdata = mem_word(m_addr);
        end else begin
          m_ack = 1'b0;
          m_rdata = 32'hCAFE_0000;
        end
        busy_cycles++;
      end else begin
        busy_cycles = 0;
        m_ack = force_ack;
        m_rdata = 32'h5A5A_5A5A;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata;
    grant_q.push_back(g);
  endtask

  task automatic expect_done(input logic is_data, input logic [31:0] rdata);
    done_t e;
    e.is_data = is_data; e.rdata = rdata;
    done_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic monitor();
    done_t  e;
    grant_t g;
    if (i_done === 1'b1 || d_done === 1'b1) begin
      seen_done = 1'b1;
      check_output("done_exclusive", 32'(i_done & d_done), 32'd0);
      compared++;
      assert (done_q.size() != 0) else begin
        mismatched++;
        $error("[TB] FAIL unexpected_done: observed i_done=%b d_done=%b expected no pulse", i_done, d_done);
      end
      if (done_q.size() != 0) begin
        e = done_q.pop_front();
        check_output("done_owner", 32'(d_done), 32'(e.is_data));
        check_output("done_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
      end
    end
    if (m_req === 1'b1 && prev_m_req !== 1'b1) begin
      compared++;
      assert (grant_q.size() != 0) else begin
        mismatched++;
        $error("[TB] FAIL unexpected_grant: observed m_req addr %h expected no request", m_addr);
      end
      if (grant_q.size() != 0) begin
        g = grant_q.pop_front();
        check_output("grant_we", 32'(m_we), 32'(g.we));
        check_output("grant_addr", m_addr, g.addr);
        check_output("grant_wdata", m_wdata, g.wdata);
      end
    end
    prev_m_req = m_req;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int used);
    seen_done = 1'b0;
    used = 0;
    while (!seen_done && used < budget) begin
      tick();
      used++;
    end
    compared++;
    assert (seen_done) else begin
      mismatched++;
      $error("[TB] FAIL done_wait: observed no done in %0d cycles expected a done pulse", budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: observed simulation still running expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int used;
    rst = 1'b1; ack_enable = 1'b1; ack_delay = 0; force_ack = 1'b0; prev_m_req = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    check_output("rst_m_req", 32'(m_req), 32'd0);
    check_output("rst_m_we", 32'(m_we), 32'd0);
    check_output("rst_m_addr", m_addr, 32'd0);
    check_output("rst_m_wdata", m_wdata, 32'd0);
    check_output("rst_i_done", 32'(i_done), 32'd0);
    check_output("rst_d_done", 32'(d_done), 32'd0);
    check_output("rst_i_rdata", i_rdata, 32'd0);
    check_output("rst_d_rdata", d_rdata, 32'd0);
    check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] T1 fetch only, minimum latency");
    expect_grant(1'b0, 32'h40, 32'h0);
    expect_done(1'b0, 32'h0050_0093);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    #1;
    check_output("t1_stall_n", 32'(stall), 32'd1);
    tick();
    check_output("t1_m_req", 32'(m_req), 32'd1);
    check_output("t1_m_we", 32'(m_we), 32'd0);
    check_output("t1_stall_n1", 32'(stall), 32'd1);
    tick();
    check_output("t1_i_done", 32'(i_done), 32'd1);
    check_output("t1_i_rdata", i_rdata, 32'h0050_0093);
    check_output("t1_stall_done", 32'(stall), 32'd0);
    tick();
    i_req = 1'b0;
    tick();
    check_output("t1_i_done_low", 32'(i_done), 32'd0);

    $display("[TB] T2 simultaneous fetch and store");
    expect_grant(1'b1, 32'h100, 32'hDEAD_BEEF);
    expect_grant(1'b0, 32'h80, 32'h0);
    expect_done(1'b1, 32'h0);
    expect_done(1'b0, mem_word(32'h80));
    apply_stimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    wait_done(10, used);
    d_req = 1'b0; d_we = 1'b0;
    wait_done(10, used);
    i_req = 1'b0;
    tick();

    $display("[TB] T3 starvation guard");
    for (int k = 0; k < 4; k++) expect_grant(1'b0, 32'h300 + 32'(4 * k), 32'h0);
    expect_grant(1'b0, 32'h200, 32'h0);
    expect_grant(1'b0, 32'h310, 32'h0);
    expect_grant(1'b0, 32'h314, 32'h0);
    expect_grant(1'b0, 32'h204, 32'h0);
    for (int k = 0; k < 4; k++) expect_done(1'b1, mem_word(32'h300 + 32'(4 * k)));
    expect_done(1'b0, mem_word(32'h200));
    expect_done(1'b1, mem_word(32'h310));
    expect_done(1'b1, mem_word(32'h314));
    expect_done(1'b0, mem_word(32'h204));
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, '0);
    for (int k = 0; k < 4; k++) begin
      wait_done(10, used);
      d_addr = 32'h300 + 32'(4 * (k + 1));
    end
    wait_done(10, used);
    i_req = 1'b0;
    wait_done(10, used);
    d_addr = 32'h314; i_req = 1'b1; i_addr = 32'h204;
    wait_done(10, used);
    d_req = 1'b0;
    wait_done(10, used);
    i_req = 1'b0;
    tick();

    $display("[TB] T4 watchdog expiry");
    ack_enable = 1'b0;
    expect_grant(1'b0, 32'h400, 32'h0);
    expect_done(1'b0, 32'h0000_0013);
    apply_stimulus(1'b1, 32'h400, 1'b0, 1'b0, '0, '0);
    wait_done(300, used);
    i_req = 1'b0;
    compared++;
    assert (used >= 257 && used <= 258) else begin
      mismatched++;
      $error("[TB] FAIL t4_wdog_cycles: observed %0d expected 257..258", used);
    end
    check_output("t4_timeout_err", 32'(timeout_err), 32'd1);
    repeat (3) tick();
    ack_enable = 1'b1;
    expect_grant(1'b0, 32'h44, 32'h0);
    expect_done(1'b0, mem_word(32'h44));
    i_req = 1'b1; i_addr = 32'h44;
    wait_done(10, used);
    i_req = 1'b0;
    check_output("t4_timeout_sticky", 32'(timeout_err), 32'd1);

    $display("[TB] T5 reset during BUSY");
    ack_enable = 1'b0;
    expect_grant(1'b0, 32'h500, 32'h0);
    i_req = 1'b1; i_addr = 32'h500;
    repeat (3) tick();
    check_output("t5_busy_m_req", 32'(m_req), 32'd1);
    rst = 1'b1; i_req = 1'b0;
    tick();
    check_output("t5_rst_m_req", 32'(m_req), 32'd0);
    check_output("t5_rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0; force_ack = 1'b1;
    tick();
    check_output("t5_late_ack_i_done", 32'(i_done), 32'd0);
    check_output("t5_late_ack_d_done", 32'(d_done), 32'd0);
    check_output("t5_late_ack_m_req", 32'(m_req), 32'd0);
    tick();
    force_ack = 1'b0; ack_enable = 1'b1;
    expect_grant(1'b0, 32'h48, 32'h0);
    expect_done(1'b0, mem_word(32'h48));
    i_req = 1'b1; i_addr = 32'h48;
    tick();
    check_output("t5_idle_regrant", 32'(m_req), 32'd1);
    wait_done(10, used);
    i_req = 1'b0;
    tick();

    $display("[TB] T6 m_ack held while idle, address change in BUSY");
    force_ack = 1'b1; ack_delay = 3;
    repeat (3) tick();
    check_output("t6_idle_i_done", 32'(i_done), 32'd0);
    check_output("t6_idle_d_done", 32'(d_done), 32'd0);
    expect_grant(1'b0, 32'h600, 32'h0);
    expect_done(1'b0, mem_word(32'h600));
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    i_addr = 32'hFFFF_0000;
    tick();
    check_output("t6_m_addr_held", m_addr, 32'h600);
    check_output("t6_m_req_held", 32'(m_req), 32'd1);
    wait_done(10, used);
    i_req = 1'b0;
    repeat (2) tick();
    check_output("t6_no_spurious_done", 32'(i_done), 32'd0);
    force_ack = 1'b0; ack_delay = 0;
    repeat (2) tick();
    check_output("t6_done_q_drained", 32'(done_q.size()), 32'd0);
    check_output("t6_grant_q_drained", 32'(grant_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
